// File: rtl/imm_gen_stage.sv
`default_nettype none
// ============================================================================
// Module      : imm_gen_stage
// Description : Registered RISC-V immediate generator with valid/ready
//               handshake, optional 1-entry skid buffer and flush.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_gen_stage #(
    parameter int XLEN   = 32,
    parameter bit CSR_EN = 1'b1,
    parameter bit SKID   = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_inst,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_imm_type,
    output logic            out_illegal,
    output logic [XLEN-1:0] out_target
);

    localparam logic [1:0] c_st_empty     = 2'd0;
    localparam logic [1:0] c_st_full      = 2'd1;
    localparam logic [1:0] c_st_full_skid = 2'd2;

    localparam logic [2:0] c_imm_none  = 3'd0;
    localparam logic [2:0] c_imm_i     = 3'd1;
    localparam logic [2:0] c_imm_s     = 3'd2;
    localparam logic [2:0] c_imm_b     = 3'd3;
    localparam logic [2:0] c_imm_u     = 3'd4;
    localparam logic [2:0] c_imm_j     = 3'd5;
    localparam logic [2:0] c_imm_shamt = 3'd6;
    localparam logic [2:0] c_imm_csr   = 3'd7;

    // Bundle layout: {inst, pc, imm, type, illegal, target}
    localparam int c_bw = 32 + 3 * XLEN + 4;

    logic [4:0]      w_opc;
    logic [2:0]      w_f3;
    logic [31:0]     w_raw;
    logic            w_sext;
    logic            w_sh5;
    logic [2:0]      w_type;
    logic            w_ill;
    logic [XLEN-1:0] w_imm;
    logic [XLEN-1:0] w_target;
    logic [c_bw-1:0] w_dec;

    logic [1:0]      r_state;
    logic [1:0]      w_next;
    logic            r_in_ready;
    logic [c_bw-1:0] r_out;
    logic [c_bw-1:0] r_skid;
    logic            w_accept;
    logic            w_load_out_in;
    logic            w_load_out_skid;
    logic            w_load_skid;

    assign w_opc = in_inst[6:2];
    assign w_f3  = in_inst[14:12];
    assign w_sh5 = (XLEN == 64) ? in_inst[25] : 1'b0;

    always_comb begin
        w_raw  = '0;
        w_sext = 1'b0;
        w_type = c_imm_none;
        w_ill  = 1'b0;
        if (in_inst[1:0] != 2'b11) begin
            w_ill = 1'b1;
        end else begin
            case (w_opc)
                5'b00000, 5'b11001, 5'b00011: begin
                    w_raw  = {{20{in_inst[31]}}, in_inst[31:20]};
                    w_sext = 1'b1;
                    w_type = c_imm_i;
                end
                5'b00100: begin
                    if (w_f3 == 3'b001 || w_f3 == 3'b101) begin
                        w_raw  = {26'b0, w_sh5, in_inst[24:20]};
                        w_type = c_imm_shamt;
                    end else begin
                        w_raw  = {{20{in_inst[31]}}, in_inst[31:20]};
                        w_sext = 1'b1;
                        w_type = c_imm_i;
                    end
                end
                5'b01000: begin
                    w_raw  = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
                    w_sext = 1'b1;
                    w_type = c_imm_s;
                end
                5'b11000: begin
                    w_raw  = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                              in_inst[30:25], in_inst[11:8], 1'b0};
                    w_sext = 1'b1;
                    w_type = c_imm_b;
                end
                5'b11011: begin
                    w_raw  = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                              in_inst[20], in_inst[30:21], 1'b0};
                    w_sext = 1'b1;
                    w_type = c_imm_j;
                end
                5'b01101, 5'b00101: begin
                    w_raw  = {in_inst[31:12], 12'b0};
                    w_sext = 1'b1;
                    w_type = c_imm_u;
                end
                5'b01100: begin
                    w_type = c_imm_none;
                end
                5'b11100: begin
                    if (CSR_EN) begin
                        w_raw  = {27'b0, in_inst[19:15]};
                        w_type = (w_f3 != 3'b000) ? c_imm_csr : c_imm_none;
                    end else begin
                        w_ill = 1'b1;
                    end
                end
                default: begin
                    w_ill = 1'b1;
                end
            endcase
        end
    end

    assign w_imm    = w_sext ? XLEN'($signed(w_raw)) : XLEN'(w_raw);
    assign w_target = in_pc + w_imm;
    assign w_dec    = {in_inst, in_pc, w_imm, w_type, w_ill, w_target};

    // Ready is forced low during reset so nothing is accepted into a clearing stage.
    assign in_ready  = (SKID ? r_in_ready : (!out_valid || out_ready)) && !rst;
    assign out_valid = (r_state != c_st_empty);
    assign w_accept  = in_valid && in_ready;

    always_comb begin
        w_next          = r_state;
        w_load_out_in   = 1'b0;
        w_load_out_skid = 1'b0;
        w_load_skid     = 1'b0;
        case (r_state)
            c_st_empty: begin
                if (w_accept) begin
                    w_next        = c_st_full;
                    w_load_out_in = 1'b1;
                end
            end
            c_st_full: begin
                if (w_accept && out_ready) begin
                    w_load_out_in = 1'b1;
                end else if (w_accept && SKID) begin
                    w_next      = c_st_full_skid;
                    w_load_skid = 1'b1;
                end else if (out_ready) begin
                    w_next = c_st_empty;
                end
            end
            c_st_full_skid: begin
                if (out_ready) begin
                    w_next          = c_st_full;
                    w_load_out_skid = 1'b1;
                end
            end
            default: begin
                w_next = c_st_empty;
            end
        endcase
        if (flush) begin
            w_next          = c_st_empty;
            w_load_out_in   = 1'b0;
            w_load_out_skid = 1'b0;
            w_load_skid     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_st_empty;
            r_in_ready <= 1'b1;
            r_out      <= '0;
            r_skid     <= '0;
        end else begin
            r_state    <= w_next;
            r_in_ready <= (w_next != c_st_full_skid);
            if (w_load_out_in) begin
                r_out <= w_dec;
            end else if (w_load_out_skid) begin
                r_out <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= w_dec;
            end
        end
    end

    assign {out_inst, out_pc, out_imm, out_imm_type, out_illegal, out_target} = r_out;

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_imm_gen_stage
// Description : Directed scoreboard bench for imm_gen_stage (CSR_EN=1 and 0).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_gen_stage;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [31:0] out_imm;
    logic [2:0]  out_imm_type;
    logic        out_illegal;
    logic [31:0] out_target;

    logic        b_in_ready;
    logic        b_out_valid;
    logic [31:0] b_out_inst;
    logic [31:0] b_out_pc;
    logic [31:0] b_out_imm;
    logic [2:0]  b_out_imm_type;
    logic        b_out_illegal;
    logic [31:0] b_out_target;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] target;
        logic [2:0]  typ;
        logic        ill;
        logic        ill_b;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   last_acc;

    imm_gen_stage #(.XLEN(32), .CSR_EN(1'b1), .SKID(1'b1)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
        .out_pc(out_pc), .out_imm(out_imm), .out_imm_type(out_imm_type),
        .out_illegal(out_illegal), .out_target(out_target)
    );

    imm_gen_stage #(.XLEN(32), .CSR_EN(1'b0), .SKID(1'b1)) dut_b (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_inst(b_out_inst),
        .out_pc(b_out_pc), .out_imm(b_out_imm), .out_imm_type(b_out_imm_type),
        .out_illegal(b_out_illegal), .out_target(b_out_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: score handshakes just before the edge, then step past it.
    task automatic tick();
        exp_t e;
        bit   acc_in;
        bit   acc_out;
        @(negedge clk);
        acc_in  = in_valid && in_ready && !flush && !rst;
        acc_out = out_valid && out_ready && !flush && !rst;
        if (acc_out) begin
            chk("output_expected", {63'b0, sb.size() != 0}, 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("inst",      out_inst,      e.inst);
                chk("pc",        out_pc,        e.pc);
                chk("imm",       out_imm,       e.imm);
                chk("imm_type",  out_imm_type,  e.typ);
                chk("illegal",   out_illegal,   e.ill);
                chk("target",    out_target,    e.target);
                chk("b_valid",   b_out_valid,   64'd1);
                chk("b_illegal", b_out_illegal, e.ill_b);
            end
        end
        if (flush || rst) sb.delete();
        if (acc_in) sb.push_back(cur);
        last_acc = acc_in;
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [31:0] inst, input logic [31:0] pc,
                          input logic [31:0] imm, input logic [2:0] typ,
                          input logic ill, input logic ill_b);
        in_inst    = inst;
        in_pc      = pc;
        in_valid   = 1'b1;
        cur.inst   = inst;
        cur.pc     = pc;
        cur.imm    = imm;
        cur.target = pc + imm;
        cur.typ    = typ;
        cur.ill    = ill;
        cur.ill_b  = ill_b;
    endtask

    task automatic send1(input logic [31:0] inst, input logic [31:0] pc,
                         input logic [31:0] imm, input logic [2:0] typ,
                         input logic ill, input logic ill_b);
        set_in(inst, pc, imm, typ, ill, ill_b);
        tick();
    endtask

    task automatic drain();
        for (int i = 0; i < 12 && sb.size() != 0; i++) tick();
        chk("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        bit done;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_inst   = '0;
        in_pc     = '0;
        out_ready = 1'b0;
        tick();
        tick();
        chk("rst_out_valid", out_valid,   64'd0);
        chk("rst_in_ready",  in_ready,    64'd0);
        chk("rst_imm",       out_imm,     64'd0);
        chk("rst_target",    out_target,  64'd0);
        chk("rst_inst",      out_inst,    64'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 64'd1);

        // Streaming decode with the sink always ready
        out_ready = 1'b1;
        send1(32'hFFF00093, 32'h0000_0000, 32'hFFFF_FFFF, 3'd1, 1'b0, 1'b0);
        chk("latency_out_valid", out_valid, 64'd1);
        send1(32'hFE112E23, 32'h0000_0010, 32'hFFFF_FFFC, 3'd2, 1'b0, 1'b0);
        send1(32'h4030D093, 32'h0000_0020, 32'h0000_0003, 3'd6, 1'b0, 1'b0);
        send1(32'hFE000CE3, 32'h0000_0100, 32'hFFFF_FFF8, 3'd3, 1'b0, 1'b0);
        send1(32'hFE000CE3, 32'h0000_0004, 32'hFFFF_FFF8, 3'd3, 1'b0, 1'b0);
        send1(32'h001000EF, 32'h0000_1000, 32'h0000_0800, 3'd5, 1'b0, 1'b0);
        send1(32'h123452B7, 32'h0000_2000, 32'h1234_5000, 3'd4, 1'b0, 1'b0);
        send1(32'h002081B3, 32'h0000_0030, 32'h0000_0000, 3'd0, 1'b0, 1'b0);
        send1(32'h00000000, 32'h0000_0034, 32'h0000_0000, 3'd0, 1'b1, 1'b1);
        send1(32'h34029073, 32'h0000_0040, 32'h0000_0005, 3'd7, 1'b0, 1'b1);
        send1(32'h00000073, 32'h0000_0044, 32'h0000_0000, 3'd0, 1'b0, 1'b1);
        in_valid = 1'b0;
        drain();
        chk("idle_out_valid", out_valid, 64'd0);

        // Backpressure: third instruction must stall behind the full skid
        out_ready = 1'b0;
        send1(32'h00100093, 32'h0000_0200, 32'h0000_0001, 3'd1, 1'b0, 1'b0);
        send1(32'h00200113, 32'h0000_0204, 32'h0000_0002, 3'd1, 1'b0, 1'b0);
        set_in(32'h00300193, 32'h0000_0208, 32'h0000_0003, 3'd1, 1'b0, 1'b0);
        chk("bp_in_ready_low", in_ready, 64'd0);
        chk("bp_head_inst",    out_inst, 64'h0010_0093);
        tick();
        tick();
        chk("bp_hold_inst",  out_inst,  64'h0010_0093);
        chk("bp_hold_imm",   out_imm,   64'd1);
        chk("bp_hold_valid", out_valid, 64'd1);
        out_ready = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 10 && !done; i++) begin
            tick();
            if (last_acc) done = 1'b1;
        end
        chk("bp_third_accepted", {63'b0, done}, 64'd1);
        in_valid = 1'b0;
        drain();

        // Flush from FULL_SKID with a pending input
        out_ready = 1'b0;
        send1(32'h00400213, 32'h0000_0300, 32'h0000_0004, 3'd1, 1'b0, 1'b0);
        send1(32'h00500293, 32'h0000_0304, 32'h0000_0005, 3'd1, 1'b0, 1'b0);
        set_in(32'h00600313, 32'h0000_0308, 32'h0000_0006, 3'd1, 1'b0, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_out_valid",   out_valid,   64'd0);
        chk("flush_in_ready",    in_ready,    64'd1);
        chk("flush_b_out_valid", b_out_valid, 64'd0);
        // An input accepted in the flush cycle is dropped
        set_in(32'h00700393, 32'h0000_030C, 32'h0000_0007, 3'd1, 1'b0, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_accept_dropped", out_valid, 64'd0);
        out_ready = 1'b1;
        send1(32'h00000013, 32'h0000_0400, 32'h0000_0000, 3'd1, 1'b0, 1'b0);
        in_valid = 1'b0;
        chk("post_flush_valid", out_valid, 64'd1);
        drain();
        tick();
        chk("post_flush_idle", out_valid, 64'd0);

        // Reset while holding entries
        out_ready = 1'b0;
        send1(32'h00800413, 32'h0000_0500, 32'h0000_0008, 3'd1, 1'b0, 1'b0);
        send1(32'h00900493, 32'h0000_0504, 32'h0000_0009, 3'd1, 1'b0, 1'b0);
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        chk("midrst_out_valid", out_valid, 64'd0);
        chk("midrst_in_ready",  in_ready,  64'd0);
        chk("midrst_imm",       out_imm,   64'd0);
        rst = 1'b0;
        #1;
        chk("midrst_release_ready", in_ready, 64'd1);
        tick();
        chk("midrst_stays_empty", out_valid, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/imm_gen_stage.md
Name: imm_gen_stage

Overview:
Registered, parametrised immediate-generation stage for the RISC-V decode path.
- Accepts one instruction and its PC per valid/ready handshake.
- Produces the sign- or zero-extended immediate, an immediate-type code, an illegal-opcode flag, and a precomputed PC-relative target (pc + imm).
- Sits between fetch/instruction-memory output and the decode/execute register.
- Optional 1-entry skid buffer keeps in_ready registered under backpressure; supports flush for branch mispredict/redirect.

Parameters:
- XLEN, 32: datapath width of pc, imm and target. Legal values are 32 and 64.
- CSR_EN, 1: when 1, CSR zimm (inst[19:15] zero-extended) is decoded; when 0, opcode 11100 is illegal.
- SKID, 1: when 1, a 1-entry skid buffer is present and in_ready is registered; when 0, in_ready = !out_valid || out_ready.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  discard all held and incoming instructions this cycle
- in_valid  in  1  input instruction valid
- in_ready  out  1  stage can accept input
- in_inst  in  32  instruction word
- in_pc  in  XLEN  instruction address
- out_valid  out  1  output valid
- out_ready  in  1  downstream accepts output
- out_inst  out  32  registered instruction
- out_pc  out  XLEN  registered PC
- out_imm  out  XLEN  extended immediate
- out_imm_type  out  3  0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT, 7 CSR
- out_illegal  out  1  unrecognised opcode or inst[1:0] != 2'b11
- out_target  out  XLEN  out_pc + out_imm, modulo 2^XLEN

Behaviour:
- Reset is synchronous on rst=1.
  - out_valid=0; all data outputs 0; skid empty.
  - in_ready=0 while rst=1, and 1 in the first cycle after rst deasserts.
- Decode by opcode inst[6:2]; I/S/B/J immediates are sign-extended from inst[31] to XLEN:
  - LOAD 00000, JALR 11001, FENCE 00011: type I.
  - OP-IMM 00100:
    - funct3 001/101: type SHAMT, zero-extended inst[24:20] (XLEN=32) or inst[25:20] (XLEN=64).
    - otherwise: type I.
  - STORE 01000: type S.
  - BRANCH 11000: type B, bit0=0.
  - JAL 11011: type J, bit0=0.
  - LUI 01101, AUIPC 00101: type U, {inst[31:12],12'b0} sign-extended to XLEN.
  - OP 01100: type NONE, imm=0, legal.
  - SYSTEM 11100 with CSR_EN=1: type CSR when funct3 != 000, otherwise NONE; imm = zero-extended inst[19:15].
  - Anything else, including SYSTEM with CSR_EN=0: type NONE, imm=0, out_illegal=1.
- Latency: exactly 1 cycle from an accepted input to out_valid when the stage is empty.
- Handshake:
  - Transfer occurs on valid&&ready at either port.
  - out_* stay stable while out_valid=1 and out_ready=0.
  - in_valid may drop without being accepted.
- State machine (SKID=1):
  - EMPTY: accept → FULL.
  - FULL:
    - accept and !out_ready → FULL_SKID; the new entry goes to the skid register and in_ready becomes 0 next cycle.
    - accept and out_ready → FULL; the output register is replaced.
    - !accept and out_ready → EMPTY.
  - FULL_SKID: in_ready=0; on out_ready the skid entry moves to the output register → FULL.
- SKID=0: no FULL_SKID state; in_ready is combinational.
- Order is strictly preserved; no drop or duplication except on flush.
- Flush:
  - Next cycle out_valid=0 and the skid is empty.
  - An input accepted in the flush cycle is discarded.
  - Flush has priority over a simultaneous accept or out_ready.
  - in_ready=1 in the cycle after a flush.
- rst mid-operation: same as reset; held entries are discarded.
- out_target is registered together with out_imm; wraps modulo 2^XLEN; computed for all types (consumers ignore it when not applicable).

Test Plan:
- Reset, then in_inst=0xFFF00093 (addi x1,x0,-1), pc=0 → next cycle out_valid=1, out_imm=0xFFFFFFFF, type=1, illegal=0.
- 0xFE112E23 (sw x1,-4(x2)) → imm=0xFFFFFFFC, type=2. 0x4030D093 (srai x1,x1,3) → imm=0x00000003, type=6.
- 0xFE000CE3 (beq -8) at pc=0x100 → imm=0xFFFFFFF8, target=0x000000F8. 0x001000EF (jal +2048) at pc=0x1000 → imm=0x800, target=0x1800. 0x123452B7 (lui) → imm=0x12345000, type=4.
- Backpressure (SKID=1): out_ready=0, send 3 instructions back-to-back.
  - First held on out_*, second in skid, in_ready=0 on cycle 3.
  - Raise out_ready → outputs appear in order with no loss.
- Flush with stage in FULL_SKID and in_valid=1 → next cycle out_valid=0, in_ready=1; the flushed and simultaneous inputs never appear. 0x00000013 then accepted normally.
- Illegal inputs: 0x00000000 → illegal=1, type=0, imm=0. With CSR_EN=0, 0x34029073 → illegal=1; with CSR_EN=1, same word → illegal=0, type=7, imm=0x5.
